rptr_handler: RTL and testbench

Read-side pointer and status logic for the asynchronous FIFO, operating entirely in the read clock domain. It owns the binary and Gray read pointers and publishes the Gray read pointer for synchronization into the write domain. It compares against the write-domain Gray pointer, already brought across by the external 2-flop synchronizer, to produce registered `empty`, `almost_empty`, a read-side fill level, a registered read-valid strobe, and a sticky underflow flag.

---
 rtl/rptr_handler.sv | 87 ++++++++
 tb/tb_rptr_handler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rptr_handler.sv
// Read-side pointer and status logic of the asynchronous FIFO.
// Keeps the binary/Gray read pointers in the read clock domain and derives
// empty, almost_empty, fill level, read-valid strobe and a sticky underflow
// flag from the write pointer that was already synchronized into r_clk.
module rptr_handler #(
    parameter int PTR_SIZE      = 8,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                r_clk,
    input  logic                rrst_n,
    input  logic                r_en,
    input  logic [PTR_SIZE:0]   g_wptr_sync,
    output logic [PTR_SIZE:0]   b_rptr,
    output logic [PTR_SIZE:0]   g_rptr,
    output logic                empty,
    output logic                almost_empty,
    output logic [PTR_SIZE:0]   rd_level,
    output logic                rd_valid,
    output logic                underflow
);

    localparam int                W         = PTR_SIZE + 1;
    localparam logic [PTR_SIZE:0] AE_THRESH = W'(AEMPTY_THRESH);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_SIZE:0] gray2bin(input logic [PTR_SIZE:0] g);
        logic [PTR_SIZE:0] b;
        b = '0;
        for (int i = 0; i < W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Binary to Gray: adjacent binary values map to single-bit Gray changes.
    function automatic logic [PTR_SIZE:0] bin2gray(input logic [PTR_SIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    logic              rd_acc;
    logic [PTR_SIZE:0] b_rptr_next;
    logic [PTR_SIZE:0] g_rptr_next;
    logic [PTR_SIZE:0] b_wptr_sync;
    logic [PTR_SIZE:0] level_next;
    logic              empty_next;
    logic              aempty_next;

    // Next-state pointer and status computation. A read is only accepted
    // while not empty, so the pointer can never pass the write pointer.
    always_comb begin
        rd_acc      = r_en & ~empty;
        b_rptr_next = b_rptr + {{PTR_SIZE{1'b0}}, rd_acc};
        g_rptr_next = bin2gray(b_rptr_next);
        b_wptr_sync = gray2bin(g_wptr_sync);
        // Full-width compare including the wrap bit distinguishes empty from full.
        empty_next  = (g_rptr_next == g_wptr_sync);
        // Modulo subtraction keeps the level correct across pointer wrap.
        level_next  = b_wptr_sync - b_rptr_next;
        aempty_next = (level_next <= AE_THRESH);
    end

    // Registered pointers and status; empty asserts on the edge that consumes
    // the last word, so a back-to-back read on the following edge is blocked.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            rd_valid     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            b_rptr       <= b_rptr_next;
            g_rptr       <= g_rptr_next;
            empty        <= empty_next;
            almost_empty <= aempty_next;
            rd_level     <= level_next;
            rd_valid     <= rd_acc;
            // Sticky until reset: records any read attempted while empty.
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rptr_handler.sv
// Directed, table-driven bench for rptr_handler with PTR_SIZE=3, AEMPTY_THRESH=2.
module tb_rptr_handler;

    localparam int PS = 3;

    logic          r_clk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          r_en = 1'b0;
    logic [PS:0]   g_wptr_sync = '0;
    logic [PS:0]   b_rptr;
    logic [PS:0]   g_rptr;
    logic          empty;
    logic          almost_empty;
    logic [PS:0]   rd_level;
    logic          rd_valid;
    logic          underflow;

    rptr_handler #(.PTR_SIZE(PS), .AEMPTY_THRESH(2)) dut (
        .r_clk        (r_clk),
        .rrst_n       (rrst_n),
        .r_en         (r_en),
        .g_wptr_sync  (g_wptr_sync),
        .b_rptr       (b_rptr),
        .g_rptr       (g_rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .rd_valid     (rd_valid),
        .underflow    (underflow)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] gw;
        logic [3:0] b;
        logic [3:0] g;
        logic       e;
        logic       ae;
        logic [3:0] lvl;
        logic       v;
        logic       u;
    } vec_t;

    vec_t       tbl[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [3:0] prev_g = '0;
    logic       prev_live = 1'b0;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t t);
        chk("b_rptr",       idx, b_rptr,                t.b);
        chk("g_rptr",       idx, g_rptr,                t.g);
        chk("empty",        idx, {3'b0, empty},         {3'b0, t.e});
        chk("almost_empty", idx, {3'b0, almost_empty},  {3'b0, t.ae});
        chk("rd_level",     idx, rd_level,              t.lvl);
        chk("rd_valid",     idx, {3'b0, rd_valid},      {3'b0, t.v});
        chk("underflow",    idx, {3'b0, underflow},     {3'b0, t.u});
    endtask

    // Drive one row, clock it, check outputs 1 time unit after the edge.
    task automatic apply(input int idx, input vec_t t);
        int nb;
        rrst_n      = t.rst_n;
        r_en        = t.en;
        g_wptr_sync = t.gw;
        @(posedge r_clk);
        #1;
        n_vec++;
        chk_all(idx, t);
        if (prev_live && t.rst_n) begin
            nb = $countones(prev_g ^ g_rptr);
            if (nb > 1) begin
                n_bad++;
                $display("FAIL gray_step vec %0d: %0d bits changed (%b -> %b), at most 1 allowed", idx, nb, prev_g, g_rptr);
            end
        end
        prev_g    = g_rptr;
        prev_live = t.rst_n;
    endtask

    initial begin
        vec_t rv;
        //                rst en  gw       b        g        e  ae lvl      v  u
        // reset held with read request and non-zero write pointer
        tbl.push_back('{1'b0,1'b1,4'b0111, 4'd0,  4'b0000, 1'b1,1'b1,4'd0, 1'b0,1'b0});
        tbl.push_back('{1'b0,1'b1,4'b0111, 4'd0,  4'b0000, 1'b1,1'b1,4'd0, 1'b0,1'b0});
        // fill arrival: write pointer binary 5
        tbl.push_back('{1'b1,1'b0,4'b0111, 4'd0,  4'b0000, 1'b0,1'b0,4'd5, 1'b0,1'b0});
        // drain 5 words, then underflowing read
        tbl.push_back('{1'b1,1'b1,4'b0111, 4'd1,  4'b0001, 1'b0,1'b0,4'd4, 1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,4'b0111, 4'd2,  4'b0011, 1'b0,1'b0,4'd3, 1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,4'b0111, 4'd3,  4'b0010, 1'b0,1'b1,4'd2, 1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,4'b0111, 4'd4,  4'b0110, 1'b0,1'b1,4'd1, 1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,4'b0111, 4'd5,  4'b0111, 1'b1,1'b1,4'd0, 1'b1,1'b0});
        tbl.push_back('{1'b1,1'b1,4'b0111, 4'd5,  4'b0111, 1'b1,1'b1,4'd0, 1'b0,1'b1});
        // full FIFO: write pointer binary 13, level 8
        tbl.push_back('{1'b1,1'b0,4'b1011, 4'd5,  4'b0111, 1'b0,1'b0,4'd8, 1'b0,1'b1});
        // write 14 + read on same edge, then drain to read pointer 14
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd6,  4'b0101, 1'b0,1'b0,4'd8, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd7,  4'b0100, 1'b0,1'b0,4'd7, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd8,  4'b1100, 1'b0,1'b0,4'd6, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd9,  4'b1101, 1'b0,1'b0,4'd5, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd10, 4'b1111, 1'b0,1'b0,4'd4, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd11, 4'b1110, 1'b0,1'b0,4'd3, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd12, 4'b1010, 1'b0,1'b1,4'd2, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd13, 4'b1011, 1'b0,1'b1,4'd1, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b1001, 4'd14, 4'b1001, 1'b1,1'b1,4'd0, 1'b1,1'b1});
        // wrap: write pointer binary 3 (Gray 0010) vs read pointer 14
        tbl.push_back('{1'b1,1'b0,4'b0010, 4'd14, 4'b1001, 1'b0,1'b0,4'd5, 1'b0,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b0010, 4'd15, 4'b1000, 1'b0,1'b0,4'd4, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b0010, 4'd0,  4'b0000, 1'b0,1'b0,4'd3, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b0010, 4'd1,  4'b0001, 1'b0,1'b1,4'd2, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b0010, 4'd2,  4'b0011, 1'b0,1'b1,4'd1, 1'b1,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b0010, 4'd3,  4'b0010, 1'b1,1'b1,4'd0, 1'b1,1'b1});
        // simultaneous: level 3 (write 6), then write 7 and read on one edge
        tbl.push_back('{1'b1,1'b0,4'b0101, 4'd3,  4'b0010, 1'b0,1'b0,4'd3, 1'b0,1'b1});
        tbl.push_back('{1'b1,1'b1,4'b0100, 4'd4,  4'b0110, 1'b0,1'b0,4'd3, 1'b1,1'b1});
        // level 4 (write 8) ahead of mid-operation reset
        tbl.push_back('{1'b1,1'b0,4'b1100, 4'd4,  4'b0110, 1'b0,1'b0,4'd4, 1'b0,1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(i, tbl[i]);
        end

        // Mid-operation reset pulsed between edges: outputs clear at once.
        rv = '{1'b0,1'b1,4'b1100, 4'd0, 4'b0000, 1'b1,1'b1,4'd0, 1'b0,1'b0};
        #3;
        rrst_n = 1'b0;
        r_en   = 1'b1;
        #1;
        n_vec++;
        chk_all(100, rv);
        // Still held through an edge while reset is low.
        @(posedge r_clk);
        #1;
        n_vec++;
        chk_all(101, rv);
        prev_live = 1'b0;
        // Release reset; write pointer 8 already present gives level 8.
        apply(102, '{1'b1,1'b0,4'b1100, 4'd0, 4'b0000, 1'b0,1'b0,4'd8, 1'b0,1'b0});
        apply(103, '{1'b1,1'b1,4'b1100, 4'd1, 4'b0001, 1'b0,1'b0,4'd7, 1'b1,1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
